ikaopll_slot_sequencer: RTL and testbench

IKAOPLL_SLOT_SEQUENCER -- requirements
Module: ikaopll_slot_sequencer

---
 rtl/ikaopll_slot_sequencer_if.sv | 39 +++
 rtl/ikaopll_slot_sequencer.sv | 112 +++++++++++
 tb/tb_ikaopll_slot_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ikaopll_slot_sequencer_if.sv
// Slot sequencer bundle: phiM enable and rhythm request in, phase enables and slot decodes out.
// Latency: purely wiring, no storage.
// Backpressure: none; consumers follow the active-low enables, there is no ready path.
interface ikaopll_slot_sequencer_if #(
    parameter int CH_COUNT = 9,
    parameter int FRAME_W  = 10
);
    localparam int SLOTS  = 2 * CH_COUNT;
    localparam int SLOT_W = (SLOTS > 2) ? $clog2(SLOTS) : 1;
    localparam int CH_W   = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;

    logic               i_phiM_PCEN_n;
    logic               i_RHYTHM_EN;
    logic               o_phi1_PCEN_n;
    logic               o_phi1_NCEN_n;
    logic               o_DAC_EN;
    logic [SLOT_W-1:0]  o_SLOT;
    logic [CH_W-1:0]    o_CH;
    logic               o_MnC_SEL;
    logic               o_CYCLE_00;
    logic               o_CYCLE_LAST;
    logic               o_RHY_SLOT;
    logic               o_MO_CTRL;
    logic               o_RO_CTRL;
    logic [FRAME_W-1:0] o_FRAME_CNT;

    // The sequencer drives every decode; the operator pipeline only observes.
    modport master (
        input  i_phiM_PCEN_n, i_RHYTHM_EN,
        output o_phi1_PCEN_n, o_phi1_NCEN_n, o_DAC_EN, o_SLOT, o_CH, o_MnC_SEL,
               o_CYCLE_00, o_CYCLE_LAST, o_RHY_SLOT, o_MO_CTRL, o_RO_CTRL, o_FRAME_CNT
    );

    modport slave (
        output i_phiM_PCEN_n, i_RHYTHM_EN,
        input  o_phi1_PCEN_n, o_phi1_NCEN_n, o_DAC_EN, o_SLOT, o_CH, o_MnC_SEL,
               o_CYCLE_00, o_CYCLE_LAST, o_RHY_SLOT, o_MO_CTRL, o_RO_CTRL, o_FRAME_CNT
    );
endinterface

// File: rtl/ikaopll_slot_sequencer.sv
// OPLL slot sequencer: divides phiM into phi1 edge enables and walks the 2-operator slot schedule.
// Latency: enables are combinational from the prescaler; slot decodes change on the edge after phi1 NCEN.
// Backpressure: i_phiM_PCEN_n high freezes all state and silences every enable.
module ikaopll_slot_sequencer #(
    parameter int CH_COUNT  = 9,
    parameter int DIV       = 4,
    parameter int RHYTHM_CH = 3,
    parameter int FRAME_W   = 10
) (
    input  logic                        i_EMUCLK,
    input  logic                        i_RST,
    ikaopll_slot_sequencer_if.master    seq
);
    localparam int SLOTS  = 2 * CH_COUNT;
    localparam int SLOT_W = (SLOTS > 2) ? $clog2(SLOTS) : 1;
    localparam int CH_W   = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
    localparam int PRE_W  = (DIV > 2) ? $clog2(DIV) : 1;
    // Lowest channel index taken over by rhythm; equals CH_COUNT when rhythm is disabled.
    localparam int RHY_LO = CH_COUNT - RHYTHM_CH;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0]  PRE_HALF  = PRE_W'(DIV / 2 - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);

    generate
        if (CH_COUNT < 1 || DIV < 2 || (DIV % 2) != 0 || RHYTHM_CH < 0 || RHYTHM_CH > CH_COUNT) begin : g_bad_params
            $error("ikaopll_slot_sequencer: illegal CH_COUNT/DIV/RHYTHM_CH combination");
        end
    endgenerate

    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic               mnc_q, mnc_d;
    logic               rhy_lat_q, rhy_lat_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    logic phim_en, ncen, pcen, dac, wrap;
    logic rhy_slot, bd_mod;

    // Phase enables decode straight off the prescaler and are masked by reset.
    always_comb begin
        phim_en = ~i_RST & ~seq.i_phiM_PCEN_n;
        ncen    = phim_en && (pre_q == PRE_LAST);
        pcen    = phim_en && (pre_q == PRE_HALF);
        dac     = phim_en && (pre_q == '0);
        wrap    = ncen && (slot_q == SLOT_LAST);
    end

    // Next state: prescaler on every phiM enable, slot on phi1 NCEN, frame-level state on wrap.
    always_comb begin
        pre_d     = pre_q;
        slot_d    = slot_q;
        ch_d      = ch_q;
        mnc_d     = mnc_q;
        rhy_lat_d = rhy_lat_q;
        frame_d   = frame_q;
        if (phim_en) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        end
        if (ncen) begin
            slot_d = wrap ? '0 : slot_q + 1'b1;
            ch_d   = CH_W'(slot_d >> 1);
            mnc_d  = ~slot_d[0];
        end
        if (wrap) begin
            rhy_lat_d = seq.i_RHYTHM_EN;
            frame_d   = frame_q + 1'b1;
        end
    end

    // State registers; slot 0 is a modulator slot, hence mnc resets to 1.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            pre_q     <= '0;
            slot_q    <= '0;
            ch_q      <= '0;
            mnc_q     <= 1'b1;
            rhy_lat_q <= 1'b0;
            frame_q   <= '0;
        end else begin
            pre_q     <= pre_d;
            slot_q    <= slot_d;
            ch_q      <= ch_d;
            mnc_q     <= mnc_d;
            rhy_lat_q <= rhy_lat_d;
            frame_q   <= frame_d;
        end
    end

    // Rhythm decode; the bass drum modulator stays on the melody-style path, so it is excluded from RO.
    always_comb begin
        rhy_slot = rhy_lat_q && (int'(ch_q) >= RHY_LO);
        bd_mod   = rhy_slot && mnc_q && (int'(ch_q) == RHY_LO);
    end

    // Outputs forced to their idle values while reset is held, independent of register state.
    always_comb begin
        seq.o_phi1_PCEN_n = ~pcen;
        seq.o_phi1_NCEN_n = ~ncen;
        seq.o_DAC_EN      = dac;
        seq.o_SLOT        = i_RST ? '0 : slot_q;
        seq.o_CH          = i_RST ? '0 : ch_q;
        seq.o_MnC_SEL     = i_RST | mnc_q;
        seq.o_CYCLE_00    = i_RST | (slot_q == '0);
        seq.o_CYCLE_LAST  = ~i_RST & (slot_q == SLOT_LAST);
        seq.o_RHY_SLOT    = ~i_RST & rhy_slot;
        seq.o_MO_CTRL     = ~i_RST & ~mnc_q & ~rhy_slot;
        seq.o_RO_CTRL     = ~i_RST & rhy_slot & ~bd_mod;
        seq.o_FRAME_CNT   = i_RST ? '0 : frame_q;
    end
endmodule

// File: tb/tb_ikaopll_slot_sequencer.sv
// Bench for the slot sequencer: default 9-channel instance plus a 6-channel, DIV=2, no-rhythm instance.
// Latency: expected slot records are queued ahead; monitors compare on each DAC_EN strobe.
// Backpressure: exercised by holding phiM enable high mid-slot.
module tb_ikaopll_slot_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    int n_checks = 0;
    int n_fail   = 0;

    ikaopll_slot_sequencer_if #(.CH_COUNT(9), .FRAME_W(10)) bus0 ();
    ikaopll_slot_sequencer_if #(.CH_COUNT(6), .FRAME_W(10)) bus1 ();

    ikaopll_slot_sequencer #(.CH_COUNT(9), .DIV(4), .RHYTHM_CH(3), .FRAME_W(10)) dut0 (
        .i_EMUCLK(clk), .i_RST(rst0), .seq(bus0)
    );
    ikaopll_slot_sequencer #(.CH_COUNT(6), .DIV(2), .RHYTHM_CH(0), .FRAME_W(10)) dut1 (
        .i_EMUCLK(clk), .i_RST(rst1), .seq(bus1)
    );

    typedef struct packed {
        logic [4:0] slot;
        logic [3:0] ch;
        logic       mnc;
        logic       rhy;
        logic       mo;
        logic       ro;
        logic       c00;
        logic       clast;
        logic [9:0] frame;
    } rec_t;

    // Hand-derived per-slot masks (bit n = slot n).
    localparam logic [17:0] MO_NORM = 18'h2AAAA;  // carriers 1,3,...,17
    localparam logic [17:0] MO_RHY  = 18'h00AAA;  // carriers 1,3,...,11
    localparam logic [17:0] RHY_M   = 18'h3F000;  // slots 12..17
    localparam logic [17:0] RO_M    = 18'h3E000;  // slots 13..17
    localparam logic [17:0] ZERO_M  = 18'h00000;

    rec_t q0[$];
    rec_t q1[$];
    rec_t got0, exp0, got1, exp1;

    function automatic rec_t mk(int s, int f, logic [17:0] mo_m, logic [17:0] rhy_m,
                                logic [17:0] ro_m, int last);
        rec_t r;
        r.slot  = 5'(s);
        r.ch    = 4'(s / 2);
        r.mnc   = (s % 2 == 0);
        r.rhy   = rhy_m[s];
        r.mo    = mo_m[s];
        r.ro    = ro_m[s];
        r.c00   = (s == 0);
        r.clast = (s == last);
        r.frame = 10'(f);
        return r;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_reset0();
        check("rst_pcen",  32'(bus0.o_phi1_PCEN_n), 1);
        check("rst_ncen",  32'(bus0.o_phi1_NCEN_n), 1);
        check("rst_dac",   32'(bus0.o_DAC_EN), 0);
        check("rst_slot",  32'(bus0.o_SLOT), 0);
        check("rst_ch",    32'(bus0.o_CH), 0);
        check("rst_mnc",   32'(bus0.o_MnC_SEL), 1);
        check("rst_c00",   32'(bus0.o_CYCLE_00), 1);
        check("rst_rhy",   32'(bus0.o_RHY_SLOT), 0);
        check("rst_mo",    32'(bus0.o_MO_CTRL), 0);
        check("rst_ro",    32'(bus0.o_RO_CTRL), 0);
        check("rst_frame", 32'(bus0.o_FRAME_CNT), 0);
    endtask

    // One full slot on dut0: queue its record, then spend DIV=4 clocks in it.
    task automatic slot0(int s, int f, bit rhy, bit chk_phase);
        if (rhy) q0.push_back(mk(s, f, MO_RHY, RHY_M, RO_M, 17));
        else     q0.push_back(mk(s, f, MO_NORM, ZERO_M, ZERO_M, 17));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (chk_phase) begin
                check("phase_dac",  32'(bus0.o_DAC_EN), 32'(c == 0));
                check("phase_pcen", 32'(bus0.o_phi1_PCEN_n), 32'(c != 1));
                check("phase_ncen", 32'(bus0.o_phi1_NCEN_n), 32'(c != 3));
            end
            @(posedge clk); #1;
        end
    endtask

    // One full slot on dut1 (DIV=2).
    task automatic slot1(int s, int f, bit chk_phase);
        q1.push_back(mk(s, f, MO_RHY, ZERO_M, ZERO_M, 11));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (chk_phase) begin
                check("d2_dac",  32'(bus1.o_DAC_EN), 32'(c == 0));
                check("d2_pcen", 32'(bus1.o_phi1_PCEN_n), 32'(c != 0));
                check("d2_ncen", 32'(bus1.o_phi1_NCEN_n), 32'(c != 1));
            end
            @(posedge clk); #1;
        end
    endtask

    // Monitor for dut0: every DAC strobe marks the first phiM enable of a slot.
    initial forever begin
        @(negedge clk);
        if (bus0.o_DAC_EN === 1'b1) begin
            got0 = {5'(bus0.o_SLOT), 4'(bus0.o_CH), bus0.o_MnC_SEL, bus0.o_RHY_SLOT, bus0.o_MO_CTRL,
                    bus0.o_RO_CTRL, bus0.o_CYCLE_00, bus0.o_CYCLE_LAST, bus0.o_FRAME_CNT};
            n_checks++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL stream0: unexpected slot strobe got slot=%0d frame=%0d expected none",
                         got0.slot, got0.frame);
            end else begin
                exp0 = q0.pop_front();
                if (got0 !== exp0) begin
                    n_fail++;
                    $display("FAIL stream0: got slot=%0d ch=%0d mnc=%b rhy=%b mo=%b ro=%b c00=%b last=%b frame=%0d expected slot=%0d ch=%0d mnc=%b rhy=%b mo=%b ro=%b c00=%b last=%b frame=%0d",
                             got0.slot, got0.ch, got0.mnc, got0.rhy, got0.mo, got0.ro, got0.c00, got0.clast, got0.frame,
                             exp0.slot, exp0.ch, exp0.mnc, exp0.rhy, exp0.mo, exp0.ro, exp0.c00, exp0.clast, exp0.frame);
                end
            end
        end
    end

    // Monitor for dut1.
    initial forever begin
        @(negedge clk);
        if (bus1.o_DAC_EN === 1'b1) begin
            got1 = {5'(bus1.o_SLOT), 4'(bus1.o_CH), bus1.o_MnC_SEL, bus1.o_RHY_SLOT, bus1.o_MO_CTRL,
                    bus1.o_RO_CTRL, bus1.o_CYCLE_00, bus1.o_CYCLE_LAST, bus1.o_FRAME_CNT};
            n_checks++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL stream1: unexpected slot strobe got slot=%0d frame=%0d expected none",
                         got1.slot, got1.frame);
            end else begin
                exp1 = q1.pop_front();
                if (got1 !== exp1) begin
                    n_fail++;
                    $display("FAIL stream1: got slot=%0d ch=%0d mnc=%b rhy=%b mo=%b ro=%b c00=%b last=%b frame=%0d expected slot=%0d ch=%0d mnc=%b rhy=%b mo=%b ro=%b c00=%b last=%b frame=%0d",
                             got1.slot, got1.ch, got1.mnc, got1.rhy, got1.mo, got1.ro, got1.c00, got1.clast, got1.frame,
                             exp1.slot, exp1.ch, exp1.mnc, exp1.rhy, exp1.mo, exp1.ro, exp1.c00, exp1.clast, exp1.frame);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst0 = 1'b1; bus0.i_phiM_PCEN_n = 1'b0; bus0.i_RHYTHM_EN = 1'b0;
        rst1 = 1'b1; bus1.i_phiM_PCEN_n = 1'b0; bus1.i_RHYTHM_EN = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        fork
            begin : seq_dut0
                @(negedge clk);
                check_reset0();
                @(posedge clk); #1;
                rst0 = 1'b0;
                // Frame 0: rhythm requested mid-frame, must not show up yet.
                for (int s = 0; s < 18; s++) begin
                    if (s == 5) bus0.i_RHYTHM_EN = 1'b1;
                    slot0(s, 0, 1'b0, s == 0);
                end
                // Frame 1: rhythm latched.
                for (int s = 0; s < 18; s++) slot0(s, 1, 1'b1, 1'b0);
                // Frame 2: slots 0..2, then a phiM stall inside slot 3.
                for (int s = 0; s < 3; s++) slot0(s, 2, 1'b1, 1'b0);
                q0.push_back(mk(3, 2, MO_RHY, RHY_M, RO_M, 17));
                repeat (2) @(posedge clk);
                #1;
                bus0.i_phiM_PCEN_n = 1'b1;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    check("stall_slot",  32'(bus0.o_SLOT), 3);
                    check("stall_frame", 32'(bus0.o_FRAME_CNT), 2);
                    check("stall_pcen",  32'(bus0.o_phi1_PCEN_n), 1);
                    check("stall_ncen",  32'(bus0.o_phi1_NCEN_n), 1);
                    check("stall_dac",   32'(bus0.o_DAC_EN), 0);
                    @(posedge clk); #1;
                end
                bus0.i_phiM_PCEN_n = 1'b0;
                @(negedge clk);
                check("resume_pre2_ncen", 32'(bus0.o_phi1_NCEN_n), 1);
                check("resume_pre2_pcen", 32'(bus0.o_phi1_PCEN_n), 1);
                @(posedge clk); #1;
                @(negedge clk);
                check("resume_pre3_ncen", 32'(bus0.o_phi1_NCEN_n), 0);
                @(posedge clk); #1;
                for (int s = 4; s < 9; s++) slot0(s, 2, 1'b1, 1'b0);
                // Reset in the middle of slot 9 of frame 2.
                q0.push_back(mk(9, 2, MO_RHY, RHY_M, RO_M, 17));
                @(posedge clk); #1;
                rst0 = 1'b1;
                bus0.i_RHYTHM_EN = 1'b0;
                @(negedge clk);
                check_reset0();
                @(posedge clk); #1;
                rst0 = 1'b0;
                // Fresh frame: slot 0, prescaler 0, frame 0, rhythm latch cleared.
                for (int s = 0; s < 18; s++) slot0(s, 0, 1'b0, s == 0);
                slot0(0, 1, 1'b0, 1'b0);
                bus0.i_phiM_PCEN_n = 1'b1;
            end
            begin : seq_dut1
                @(posedge clk); #1;
                rst1 = 1'b0;
                for (int f = 0; f < 2; f++)
                    for (int s = 0; s < 12; s++) slot1(s, f, f == 0 && s == 0);
                slot1(0, 2, 1'b0);
                bus1.i_phiM_PCEN_n = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        check("q0_drained", 32'(q0.size()), 0);
        check("q1_drained", 32'(q1.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
